// File: rtl/mux3_operand_sched.sv
// -----------------------------------------------------------------------------
// mux3_operand_sched
//
// Upstream operand scheduler for a 3-word, 2-select output mux stage.
// The mux selects: c2=1 -> w1, c2=0/c1=0 -> w2, c2=0/c1=1 -> w3.
// The block holds three operand words in slots 1..3 and fills them through one
// write port. It presents one full slot at a time to the consumer with a
// valid/ready handshake. Full slots are served round-robin.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      write request
//   wr_addr    target slot 1..3 (0 is ignored)
//   wr_data    word to store
//   wr_ready   combinational: wr_addr names an empty slot
//   w1..w3     slot word registers, wired to the mux data inputs
//   c1, c2     registered mux select pair
//   out_valid  the select pair names a full slot awaiting consumption
//   out_ready  consumer accepts the current selection
//   out_slot   slot currently presented (0 when idle)
//   issue_cnt  completed handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mux3_operand_sched #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [W-1:0]     wr_data,
  output logic             wr_ready,
  output logic [W-1:0]     w1,
  output logic [W-1:0]     w2,
  output logic [W-1:0]     w3,
  output logic             c1,
  output logic             c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_slot,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_n;
  logic [3:1] full;       // bit n set: slot n holds an unconsumed word
  logic [1:0] rr_ptr;     // slot where the round-robin search starts (1..3)
  logic [1:0] rr_ptr_n;
  logic [1:0] slot_n;
  logic [3:1] full_clr;
  logic [3:1] full_set;
  logic       cnt_inc;
  logic       wr_acc;

  // Slot after s in round-robin order, 3 wraps to 1.
  function automatic logic [1:0] succ(input logic [1:0] s);
    return (s == 2'd3) ? 2'd1 : s + 2'd1;
  endfunction

  function automatic logic [3:1] onehot(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // First set slot in mask, searching upward from ptr and wrapping; 0 if none.
  function automatic logic [1:0] pick(input logic [3:1] mask, input logic [1:0] ptr);
    case (ptr)
      2'd2:    return mask[2] ? 2'd2 : mask[3] ? 2'd3 : mask[1] ? 2'd1 : 2'd0;
      2'd3:    return mask[3] ? 2'd3 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd0;
      default: return mask[1] ? 2'd1 : mask[2] ? 2'd2 : mask[3] ? 2'd3 : 2'd0;
    endcase
  endfunction

  // Ready only for a legal, currently empty slot. The presented slot is full,
  // so its word cannot change while out_valid is high.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ready = 1'b0;
    case (wr_addr)
      2'd1:    wr_ready = ~full[1];
      2'd2:    wr_ready = ~full[2];
      2'd3:    wr_ready = ~full[3];
      default: wr_ready = 1'b0;
    endcase
  end

  assign wr_acc    = wr_en & wr_ready;
  assign full_set  = wr_acc ? onehot(wr_addr) : 3'b000;
  assign out_valid = (state == PRESENT);

  // Next-state and next-selection logic. Decisions use the pre-edge full
  // flags only, so a slot written on a consume edge is not yet a candidate.
  always_comb begin
    state_n  = state;
    slot_n   = out_slot;
    rr_ptr_n = rr_ptr;
    full_clr = 3'b000;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (|full) begin
          state_n = PRESENT;
          slot_n  = pick(full, rr_ptr);
        end
      end
      PRESENT: begin
        if (out_ready) begin
          full_clr = onehot(out_slot);
          cnt_inc  = 1'b1;
          rr_ptr_n = succ(out_slot);
          // Back-to-back issue: choose among the other full slots this edge.
          slot_n   = pick(full & ~full_clr, rr_ptr_n);
          if (slot_n == 2'd0) begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        slot_n  = 2'd0;
      end
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      full      <= 3'b000;
      rr_ptr    <= 2'd1;
      out_slot  <= 2'd0;
      c1        <= 1'b0;
      c2        <= 1'b0;
      issue_cnt <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
    end else begin
      state     <= state_n;
      full      <= (full & ~full_clr) | full_set;
      rr_ptr    <= rr_ptr_n;
      out_slot  <= slot_n;
      // Slot 1 -> 10, slot 2 -> 00, slot 3 -> 01; 11 is unreachable.
      c2        <= (slot_n == 2'd1);
      c1        <= (slot_n == 2'd3);
      issue_cnt <= issue_cnt + CNT_W'(cnt_inc);
      // Words are not cleared on consume; the mux output stays stable.
      if (wr_acc) begin
        case (wr_addr)
          2'd1:    w1 <= wr_data;
          2'd2:    w2 <= wr_data;
          2'd3:    w3 <= wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux3_operand_sched.sv
// -----------------------------------------------------------------------------
// Testbench for mux3_operand_sched: write-port vector table, issue scoreboard
// (expected slot/word pushed when stimulus is driven, popped on handshake),
// and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_mux3_operand_sched;

  localparam int W     = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [W-1:0]     wr_data;
  logic             wr_ready;
  logic [W-1:0]     w1, w2, w3;
  logic             c1, c2;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_slot;
  logic [CNT_W-1:0] issue_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]   slot;
    logic [W-1:0] word;
  } iss_t;
  iss_t sb[$];

  typedef struct {
    logic         en;
    logic [1:0]   addr;
    logic [W-1:0] data;
    logic         e_ready;
    logic [W-1:0] e_w1, e_w2, e_w3;
    logic         e_valid;
    logic [1:0]   e_slot;
  } vec_t;
  vec_t vecs[8];

  mux3_operand_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .c1        (c1),
    .c2        (c2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slot  (out_slot),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Select code the mux expects for each slot.
  function automatic logic [1:0] enc(input logic [1:0] s);
    case (s)
      2'd1:    return 2'b10;
      2'd2:    return 2'b00;
      2'd3:    return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Mux stage behaviour, from the select pair and word registers.
  function automatic logic [W-1:0] mux_out();
    return c2 ? w1 : (c1 ? w3 : w2);
  endfunction

  // Handshake monitor: inputs are stable at the negedge, the handshake
  // completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue at %0t: slot %0d presented, none expected", $time, out_slot);
      end else begin
        iss_t e;
        e = sb.pop_front();
        check("issue_slot", 32'(out_slot), 32'(e.slot));
        check("issue_sel",  32'({c2, c1}), 32'(enc(e.slot)));
        check("issue_word", 32'(mux_out()), 32'(e.word));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic [W-1:0] d);
    iss_t e;
    e.slot = s;
    e.word = d;
    sb.push_back(e);
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = '0;
    out_ready = 1'b0;

    //                en    addr  data  rdy   w1    w2    w3    vld   slot
    vecs[0] = '{1'b1, 2'd0, 3'd7, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 2'd2, 3'd5, 1'b1, 3'd0, 3'd5, 3'd0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 2'd2, 3'd6, 1'b0, 3'd0, 3'd5, 3'd0, 1'b1, 2'd2};
    vecs[3] = '{1'b1, 2'd1, 3'd6, 1'b1, 3'd6, 3'd5, 3'd0, 1'b1, 2'd2};
    vecs[4] = '{1'b1, 2'd1, 3'd1, 1'b0, 3'd6, 3'd5, 3'd0, 1'b1, 2'd2};
    vecs[5] = '{1'b1, 2'd3, 3'd1, 1'b1, 3'd6, 3'd5, 3'd1, 1'b1, 2'd2};
    vecs[6] = '{1'b1, 2'd3, 3'd2, 1'b0, 3'd6, 3'd5, 3'd1, 1'b1, 2'd2};
    vecs[7] = '{1'b1, 2'd0, 3'd0, 1'b0, 3'd6, 3'd5, 3'd1, 1'b1, 2'd2};

    // Reset state.
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_slot",  32'(out_slot), 0);
    check("rst_sel",   32'({c2, c1}), 0);
    check("rst_cnt",   32'(issue_cnt), 0);
    check("rst_words", 32'({w1, w2, w3}), 0);
    wr_addr = 2'd1;
    #1;
    check("rst_ready1", 32'(wr_ready), 1);

    // Write-port table, out_ready held low: slot 2 presented and held.
    for (int i = 0; i < 8; i++) begin
      wr_en   = vecs[i].en;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      #1;
      check($sformatf("v%0d_ready", i), 32'(wr_ready), 32'(vecs[i].e_ready));
      step();
      check($sformatf("v%0d_w1", i),    32'(w1), 32'(vecs[i].e_w1));
      check($sformatf("v%0d_w2", i),    32'(w2), 32'(vecs[i].e_w2));
      check($sformatf("v%0d_w3", i),    32'(w3), 32'(vecs[i].e_w3));
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_slot", i),  32'(out_slot), 32'(vecs[i].e_slot));
      if (vecs[i].e_valid)
        check($sformatf("v%0d_sel", i), 32'({c2, c1}), 32'(enc(vecs[i].e_slot)));
    end
    wr_en = 1'b0;
    // Drain: 2 presented, then from pointer 3: slot 3, then slot 1.
    push(2'd2, 3'd5);
    push(2'd3, 3'd1);
    push(2'd1, 3'd6);
    out_ready = 1'b1;
    step();
    check("drain_b2b1", 32'(out_valid), 1);
    step();
    check("drain_b2b2", 32'(out_valid), 1);
    step();
    check("drain_idle", 32'(out_valid), 0);
    check("drain_cnt",  32'(issue_cnt), 3);

    // Fill 1,2,3 then drain back-to-back in order 1,2,3.
    do_reset();
    wr(2'd1, 3'b110);
    wr(2'd2, 3'b011);
    wr(2'd3, 3'b001);
    check("fill_slot", 32'(out_slot), 1);
    push(2'd1, 3'b110);
    push(2'd2, 3'b011);
    push(2'd3, 3'b001);
    out_ready = 1'b1;
    step();
    check("ord_s2", 32'(out_slot), 2);
    step();
    check("ord_s3", 32'(out_slot), 3);
    step();
    check("ord_idle", 32'(out_valid), 0);
    check("ord_cnt",  32'(issue_cnt), 3);

    // Round-robin after consuming slot 3: pointer is 1.
    out_ready = 1'b0;
    wr(2'd1, 3'd2);
    wr(2'd3, 3'd4);
    push(2'd1, 3'd2);
    push(2'd3, 3'd4);
    out_ready = 1'b1;
    step();
    step();
    check("rr_idle", 32'(out_valid), 0);
    check("rr_cnt",  32'(issue_cnt), 5);
    // Only slot 3 full again: found after the search wraps, no lockout.
    out_ready = 1'b0;
    wr(2'd3, 3'd5);
    step();
    check("rr3_valid", 32'(out_valid), 1);
    check("rr3_slot",  32'(out_slot), 3);
    push(2'd3, 3'd5);
    out_ready = 1'b1;
    step();
    check("rr3_idle", 32'(out_valid), 0);
    check("rr3_cnt",  32'(issue_cnt), 6);

    // Same-cycle write of the consumed slot is refused.
    out_ready = 1'b0;
    wr(2'd1, 3'd7);
    step();
    check("sc_present", 32'(out_slot), 1);
    push(2'd1, 3'd7);
    out_ready = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 2'd1;
    wr_data   = 3'd0;
    #1;
    check("sc_same_ready", 32'(wr_ready), 0);
    step();
    wr_en = 1'b0;
    check("sc_same_w1",    32'(w1), 7);
    check("sc_same_idle",  32'(out_valid), 0);
    // Same-cycle write of an empty slot is accepted but picked up later.
    out_ready = 1'b0;
    wr(2'd1, 3'd4);
    step();
    push(2'd1, 3'd4);
    push(2'd2, 3'd2);
    out_ready = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 2'd2;
    wr_data   = 3'd2;
    #1;
    check("sc_diff_ready", 32'(wr_ready), 1);
    step();
    wr_en = 1'b0;
    check("sc_diff_w2",    32'(w2), 2);
    check("sc_diff_bubble", 32'(out_valid), 0);
    step();
    check("sc_diff_valid", 32'(out_valid), 1);
    check("sc_diff_slot",  32'(out_slot), 2);
    step();
    check("sc_diff_idle",  32'(out_valid), 0);
    check("sc_diff_cnt",   32'(issue_cnt), 9);

    // 256 handshakes: issue_cnt wraps to 0.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [1:0]   s;
      logic [W-1:0] d;
      s = 2'((i % 3) + 1);
      d = W'(i);
      push(s, d);
      wr(s, d);
      step();
      step();
      if (i == 254) check("wrap_255", 32'(issue_cnt), 255);
    end
    check("wrap_0",    32'(issue_cnt), 0);
    check("wrap_idle", 32'(out_valid), 0);

    // Reset while presenting, with wr_en and out_ready asserted.
    do_reset();
    wr(2'd1, 3'd3);
    wr(2'd2, 3'd5);
    push(2'd1, 3'd3);
    out_ready = 1'b1;
    step();
    check("mr_pre_valid", 32'(out_valid), 1);
    check("mr_pre_cnt",   32'(issue_cnt), 1);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 3'd6;
    step();
    rst       = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b0;
    check("mr_valid", 32'(out_valid), 0);
    check("mr_sel",   32'({c2, c1}), 0);
    check("mr_slot",  32'(out_slot), 0);
    check("mr_cnt",   32'(issue_cnt), 0);
    check("mr_words", 32'({w1, w2, w3}), 0);
    for (int a = 1; a <= 3; a++) begin
      wr_addr = 2'(a);
      #1;
      check($sformatf("mr_empty%0d", a), 32'(wr_ready), 1);
    end
    step();
    check("mr_stay_idle", 32'(out_valid), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux3_operand_sched.md
Name: mux3_operand_sched

Overview:
- Upstream operand scheduler for the 3-word, 2-select output mux stage.
- Holds three W-bit operand words in slots 1..3, accepts writes through a single write port, and issues one slot at a time to the mux.
- Each issue drives the select pair c1/c2 and uses a valid/ready handshake.
- The mux stage computes: c2=1 → word1; c2=0,c1=0 → word2; c2=0,c1=1 → word3. This block must only produce those three select codes.

Parameters:
W, 3, operand word width (matches mux data width)
CNT_W, 8, width of issue counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
wr_addr  input  2  target slot: 1, 2 or 3; 0 is illegal and ignored
wr_data  input  W  word to store
wr_ready  output  1  combinational: slot wr_addr is empty and wr_addr != 0
w1  output  W  slot 1 word register (feeds mux w1)
w2  output  W  slot 2 word register (feeds mux w2)
w3  output  W  slot 3 word register (feeds mux w3)
c1  output  1  select bit 1 (registered)
c2  output  1  select bit 2 (registered)
out_valid  output  1  c1/c2 denote a full slot awaiting consumption
out_ready  input  1  consumer accepts current selection
out_slot  output  2  slot currently presented (0 when idle)
issue_cnt  output  CNT_W  completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset: w1..w3=0, slot full flags=0, c1=0, c2=0, out_valid=0, out_slot=0, issue_cnt=0, rr pointer=slot 1, state IDLE.
- Write:
  - Accepted iff wr_en & wr_ready.
  - Accepted write loads the word register and sets the full flag at the edge.
  - Write to a full slot or to addr 0: no state change.
- Slot encoding: slot1 → c2=1,c1=0; slot2 → c2=0,c1=0; slot3 → c2=0,c1=1. c1=c2=1 must never be driven.
- FSM with states IDLE and PRESENT:
  - IDLE: out_valid=0, out_slot=0, c1=c2=0.
    - If any full flag is set, go to PRESENT next edge.
    - The slot presented is the first full slot searching from the rr pointer upward, wrapping 3→1.
  - PRESENT: out_valid=1; c1, c2 and out_slot are held stable until handshake.
  - Handshake (out_valid & out_ready at an edge):
    - Clear the presented slot's full flag.
    - Increment issue_cnt.
    - Set rr pointer to presented slot+1 (3 wraps to 1).
    - In the same edge, choose the next full slot, excluding the one just consumed, from the new pointer.
    - If one is found, stay in PRESENT with the new select: back-to-back, no bubble.
    - Otherwise go to IDLE.
  - No handshake: hold everything.
- Latency: a write accepted at edge t is seen by the full flag after t; out_valid rises after edge t+1 when starting from IDLE.
- Word registers are not cleared on consume. Data stays visible and the mux output stays stable through the handshake.
- Write to the presented slot is refused, since that slot is full. This guarantees the presented word is stable while out_valid=1.
- Simultaneous write of slot A and consume of slot A in the same cycle: the write is refused, because wr_ready is computed from the pre-edge full flag.
- Simultaneous write of slot B (empty) and consume of slot A:
  - Both take effect.
  - B is not a candidate for the next-select decision on that edge, because it was not full pre-edge.
  - B is picked up on a later edge.
- issue_cnt wraps from 2^CNT_W-1 to 0.
- rst asserted mid-operation: all state returns to reset values on the next edge, regardless of wr_en/out_ready.

Test Plan:
- After reset, write slot2=3'b101 with out_ready=0 → out_valid=1 two edges later, c2=0, c1=0, out_slot=2, w2=101, and the select holds indefinitely.
- Fill slots 1,2,3 (110,011,001), then hold out_ready=1 → back-to-back issue order 1,2,3 (c2c1 = 10, 00, 01), then IDLE; issue_cnt=3.
- Round-robin wrap:
  - Consume slot 3, then refill slots 1 and 3 → next issue is slot 1, then slot 3.
  - Repeat with only slot 3 full after consuming 3 → slot 3 is re-issued only after the pointer wraps, with no lockout.
- Write attempt to the presented slot and to addr 0 → wr_ready=0, word register unchanged. Same-cycle write of the consumed slot is refused; same-cycle write of a different empty slot is accepted.
- 256 handshakes with CNT_W=8 → issue_cnt returns to 0.
- Assert rst while out_valid=1 → next cycle: out_valid=0, c1=c2=0, all full flags clear, issue_cnt=0.
